wb_sequencer: RTL and testbench



---
 rtl/wb_pkg.sv | 44 ++++
 rtl/wb_pending_slot.sv | 34 +++
 rtl/wb_sequencer.sv | 140 ++++++++++++++
 tb/tb_wb_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back sequencer.
// Covers state encoding, source/destination codes and source classification.
package wb_pkg;

  localparam int unsigned SRC_W = 4;
  localparam int unsigned DST_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_WAIT_MD  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_ERR      = 3'd4
  } state_t;

  localparam logic [SRC_W-1:0] SRC_ALU   = 4'b0000;
  localparam logic [SRC_W-1:0] SRC_MEM   = 4'b0001;
  localparam logic [SRC_W-1:0] SRC_HI    = 4'b0010;
  localparam logic [SRC_W-1:0] SRC_LO    = 4'b0011;
  localparam logic [SRC_W-1:0] SRC_PC8   = 4'b0100;
  localparam logic [SRC_W-1:0] SRC_SHIFT = 4'b0101;
  localparam logic [SRC_W-1:0] SRC_IMM   = 4'b0110;
  localparam logic [SRC_W-1:0] SRC_VEC   = 4'b0111;
  localparam logic [SRC_W-1:0] SRC_LDX   = 4'b1000;

  localparam logic [DST_W-1:0] DST_RT = 2'd0;
  localparam logic [DST_W-1:0] DST_RD = 2'd1;
  localparam logic [DST_W-1:0] DST_RA = 2'd2;
  localparam logic [DST_W-1:0] DST_SP = 2'd3;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [DST_W-1:0] dst;
  } wb_entry_t;

  function automatic logic is_mem_src(input logic [SRC_W-1:0] src);
    return (src == SRC_MEM) || (src == SRC_LDX);
  endfunction

  function automatic logic is_md_src(input logic [SRC_W-1:0] src);
    return (src == SRC_HI) || (src == SRC_LO);
  endfunction

endpackage

// File: rtl/wb_pending_slot.sv
// One-entry holding buffer for a write-back request that arrived while busy.
// A simultaneous pop and push replaces the entry and keeps the slot full.
module wb_pending_slot
  import wb_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      full,
  output logic      full_nxt_c
);

  always_comb begin
    full_nxt_c = full;
    if (flush)     full_nxt_c = 1'b0;
    else if (push) full_nxt_c = 1'b1;
    else if (pop)  full_nxt_c = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      dout <= '0;
    end else begin
      full <= full_nxt_c;
      if (push && !flush) dout <= din;
    end
  end

endmodule

// File: rtl/wb_sequencer.sv
// Write-back controller: waits for the selected source to become valid, then
// issues a single-cycle register-file write; one request may be queued behind.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_req,
  input  logic [SRC_W-1:0] wb_src,
  input  logic [DST_W-1:0] wb_dst,
  input  logic             md_done,
  input  logic             flush,
  output logic [SRC_W-1:0] mem_to_reg,
  output logic [DST_W-1:0] reg_dst,
  output logic             reg_write,
  output logic             wb_busy,
  output logic             wb_done,
  output logic             wb_err,
  output logic             wb_overrun
);

  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] MD_LAST  = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             slot_full, slot_full_n;
  wb_entry_t        slot_q, new_req, disp_req;
  logic             push, pop, disp, overrun_n, taken_direct;

  assign new_req = '{src: wb_src, dst: wb_dst};
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  wb_pending_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .din        (new_req),
    .dout       (slot_q),
    .full       (slot_full),
    .full_nxt_c (slot_full_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, counter and slot control; the queued entry has dispatch priority.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    push         = 1'b0;
    pop          = 1'b0;
    disp         = 1'b0;
    disp_req     = '0;
    overrun_n    = 1'b0;
    taken_direct = 1'b0;
    if (flush) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        ST_WAIT_MEM: begin
          if (cnt == MEM_LAST) state_n = ST_WRITE;
          else                 cnt_n   = cnt_inc;
        end
        ST_WAIT_MD: begin
          if (md_done)             state_n = ST_WRITE;
          else if (cnt == MD_LAST) state_n = ST_ERR;
          else                     cnt_n   = cnt_inc;
        end
        default: begin
          if (slot_full) begin
            disp     = 1'b1;
            disp_req = slot_q;
            pop      = 1'b1;
          end else if (wb_req) begin
            disp         = 1'b1;
            disp_req     = new_req;
            taken_direct = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      endcase

      if (wb_req && !taken_direct) begin
        if (!slot_full || pop) push      = 1'b1;
        else                   overrun_n = 1'b1;
      end

      if (disp) begin
        cnt_n = '0;
        if (is_md_src(disp_req.src))                      state_n = ST_WAIT_MD;
        else if (is_mem_src(disp_req.src) && MEM_LAT != 0) state_n = ST_WAIT_MEM;
        else                                              state_n = ST_WRITE;
      end
    end
  end

  // Outputs are registered from the next-state view so they align with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_to_reg <= '0;
      reg_dst    <= '0;
      reg_write  <= 1'b0;
      wb_busy    <= 1'b0;
      wb_done    <= 1'b0;
      wb_err     <= 1'b0;
      wb_overrun <= 1'b0;
    end else begin
      reg_write  <= (state_n == ST_WRITE);
      wb_done    <= (state_n == ST_WRITE);
      wb_err     <= (state_n == ST_ERR);
      wb_overrun <= overrun_n;
      wb_busy    <= (state_n != ST_IDLE) || slot_full_n;
      if (disp) begin
        mem_to_reg <= disp_req.src;
        reg_dst    <= disp_req.dst;
      end else if (state_n == ST_IDLE || state_n == ST_ERR) begin
        mem_to_reg <= '0;
        reg_dst    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer: directed requests push expected write,
// error and overrun events; a negedge monitor pops and compares them.
module tb_wb_sequencer;
  import wb_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wb_req = 1'b0;
  logic [3:0] wb_src = '0;
  logic [1:0] wb_dst = '0;
  logic       md_done = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] mem_to_reg;
  logic [1:0] reg_dst;
  logic       reg_write, wb_busy, wb_done, wb_err, wb_overrun;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         cyc;
    logic [3:0] src;
    logic [1:0] dst;
  } wexp_t;

  wexp_t wq[$];
  int    eq[$];
  int    oq[$];
  wexp_t me;
  int    mc;

  wb_sequencer #(.MEM_LAT(2), .MD_TIMEOUT(40), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_req     (wb_req),
    .wb_src     (wb_src),
    .wb_dst     (wb_dst),
    .md_done    (md_done),
    .flush      (flush),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .wb_busy    (wb_busy),
    .wb_done    (wb_done),
    .wb_err     (wb_err),
    .wb_overrun (wb_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wb_req = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic req(input logic [3:0] s, input logic [1:0] d, output int n);
    wb_req = 1'b1;
    wb_src = s;
    wb_dst = d;
    n      = cyc;
  endtask

  task automatic exp_write(input int c, input logic [3:0] s, input logic [1:0] d);
    wexp_t e;
    e.cyc = c;
    e.src = s;
    e.dst = d;
    wq.push_back(e);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_reg_write"}, 32'(reg_write), 0);
    chk({tag, "_busy"}, 32'(wb_busy), 0);
    chk({tag, "_mem_to_reg"}, 32'(mem_to_reg), 0);
    chk({tag, "_reg_dst"}, 32'(reg_dst), 0);
  endtask

  // Monitor: every observed event must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        chk("write_missed_cycle", cyc, wq[0].cyc);
        void'(wq.pop_front());
      end
      while (eq.size() > 0 && eq[0] < cyc) begin
        chk("err_missed_cycle", cyc, eq[0]);
        void'(eq.pop_front());
      end
      while (oq.size() > 0 && oq[0] < cyc) begin
        chk("overrun_missed_cycle", cyc, oq[0]);
        void'(oq.pop_front());
      end
      if (reg_write) begin
        if (wq.size() == 0) chk("unexpected_write", 32'(reg_write), 0);
        else begin
          me = wq.pop_front();
          chk("write_cycle", cyc, me.cyc);
          chk("write_src", 32'(mem_to_reg), 32'(me.src));
          chk("write_dst", 32'(reg_dst), 32'(me.dst));
          chk("write_done", 32'(wb_done), 1);
        end
      end else if (wb_done) chk("stray_done", 32'(wb_done), 0);
      if (wb_err) begin
        if (eq.size() == 0) chk("unexpected_err", 32'(wb_err), 0);
        else begin
          mc = eq.pop_front();
          chk("err_cycle", cyc, mc);
          chk("err_mem_to_reg", 32'(mem_to_reg), 0);
          chk("err_no_write", 32'(reg_write), 0);
        end
      end
      if (wb_overrun) begin
        if (oq.size() == 0) chk("unexpected_overrun", 32'(wb_overrun), 0);
        else begin
          mc = oq.pop_front();
          chk("overrun_cycle", cyc, mc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    chk_quiet("reset");
    chk("reset_err", 32'(wb_err), 0);
    chk("reset_overrun", 32'(wb_overrun), 0);
    repeat (3) tick();

    // DIRECT: write one cycle after the request, then quiet
    req(SRC_ALU, DST_RD, n);
    exp_write(n + 1, SRC_ALU, DST_RD);
    tick();
    tick();
    chk_quiet("direct_after");
    repeat (2) tick();

    // MEM: selector held through the two wait cycles, write at N+3
    req(SRC_MEM, DST_RT, n);
    exp_write(n + 3, SRC_MEM, DST_RT);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("mem_wait_sel", 32'(mem_to_reg), 32'(SRC_MEM));
      chk("mem_wait_nowrite", 32'(reg_write), 0);
      chk("mem_wait_busy", 32'(wb_busy), 1);
      tick();
    end
    repeat (3) tick();
    req(SRC_LDX, DST_SP, n);
    exp_write(n + 3, SRC_LDX, DST_SP);
    repeat (5) tick();

    // MD: md_done at N+33 gives write at N+34
    req(SRC_HI, DST_RA, n);
    exp_write(n + 34, SRC_HI, DST_RA);
    tick();
    while (cyc < n + 33) tick();
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    repeat (3) tick();

    // MD timeout: error at N+41, no write
    req(SRC_LO, DST_RD, n);
    eq.push_back(n + 41);
    repeat (44) tick();
    chk_quiet("timeout_after");

    // Pending slot and overrun
    req(SRC_MEM, DST_RT, n);
    exp_write(n + 3, SRC_MEM, DST_RT);
    exp_write(n + 4, SRC_IMM, DST_RD);
    oq.push_back(n + 3);
    tick();
    req(SRC_IMM, DST_RD, mc);
    tick();
    req(SRC_VEC, DST_SP, mc);
    repeat (4) tick();
    chk_quiet("pending_after");

    // Flush with a simultaneous request in WAIT_MD
    req(SRC_HI, DST_RT, n);
    tick();
    repeat (5) tick();
    flush = 1'b1;
    req(SRC_ALU, DST_RD, mc);
    tick();
    chk_quiet("flush_next");
    repeat (3) tick();

    // Flush during WRITE keeps that cycle's write
    req(SRC_PC8, DST_RA, n);
    exp_write(n + 1, SRC_PC8, DST_RA);
    tick();
    flush = 1'b1;
    req(SRC_MEM, DST_RT, mc);
    tick();
    chk_quiet("flush_write_next");
    repeat (3) tick();

    // Reset while waiting
    req(SRC_LO, DST_SP, n);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_quiet("midreset");
    tick();
    chk("midreset_nowrite", 32'(reg_write), 0);
    repeat (2) tick();

    // md_done already high in the request cycle: write at N+2
    req(SRC_LO, DST_RD, n);
    md_done = 1'b1;
    exp_write(n + 2, SRC_LO, DST_RD);
    tick();
    tick();
    md_done = 1'b0;
    repeat (4) tick();

    chk("writes_left", wq.size(), 0);
    chk("errs_left", eq.size(), 0);
    chk("overruns_left", oq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
